// File: rtl/tiny_cpu_mem_port.sv
// Bus initiator for the tiny CPU core: one load/store at a time over a
// multiplexed address/data cycle on the TinyTapeout uio pins.
module tiny_cpu_mem_port #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  input  logic [7:0] bus_in,
  output logic       bus_ale,
  output logic       bus_wr,
  output logic       bus_rd
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; all registers (including the request
  // latches) are reset so outputs are defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_out   = 8'h00;
    bus_oe    = 8'h00;
    bus_ale   = 1'b0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus_out = addr_q;
        bus_oe  = 8'hFF;
        bus_ale = 1'b1;
        if (we_q) begin
          cnt_d   = WAIT_LD;
          state_d = S_WDATA;
        end else begin
          state_d = S_TURN;
        end
      end
      S_WDATA: begin
        bus_out = wdata_q;
        bus_oe  = 8'hFF;
        bus_wr  = 1'b1;
        if (cnt_q == 3'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_TURN: begin
        // Neither side drives the pins for one cycle before the target replies.
        cnt_d   = WAIT_LD;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        bus_rd = 1'b1;
        if (cnt_q == 3'd0) begin
          rdata_d = bus_in;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_tiny_cpu_mem_port.sv
// Self-checking bench: three instances (WAIT_CYCLES 1, 0, 7) driven with directed
// and random transactions, checked against a cycle-timing model and a memory array.
module tb_tiny_cpu_mem_port;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n     [N];
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_we    [N];
  logic [7:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic       rsp_valid [N];
  logic [7:0] rsp_rdata [N];
  logic       busy      [N];
  logic [7:0] bus_out   [N];
  logic [7:0] bus_oe    [N];
  logic [7:0] bus_in    [N];
  logic       bus_ale   [N];
  logic       bus_wr    [N];
  logic       bus_rd    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    tiny_cpu_mem_port #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 7))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g]),
      .bus_out   (bus_out[g]),
      .bus_oe    (bus_oe[g]),
      .bus_in    (bus_in[g]),
      .bus_ale   (bus_ale[g]),
      .bus_wr    (bus_wr[g]),
      .bus_rd    (bus_rd[g])
    );
  end

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] mem       [256];
  logic [7:0] exp_rdata [N];

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input int k, input string tag);
    check({tag, "_busy"},  8'(busy[k]),      8'h00);
    check({tag, "_oe"},    bus_oe[k],        8'h00);
    check({tag, "_out"},   bus_out[k],       8'h00);
    check({tag, "_ale"},   8'(bus_ale[k]),   8'h00);
    check({tag, "_wr"},    8'(bus_wr[k]),    8'h00);
    check({tag, "_rd"},    8'(bus_rd[k]),    8'h00);
    check({tag, "_rspv"},  8'(rsp_valid[k]), 8'h00);
    check({tag, "_rdata"}, rsp_rdata[k],     exp_rdata[k]);
  endtask

  // Called at a negedge while instance k is idle; returns at a negedge while idle.
  task automatic run_txn(input int k, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit chain, input logic nwe,
                         input logic [7:0] naddr, input logic [7:0] nwdata,
                         input int abort_at);
    int         w;
    int         last;
    logic       e_wr, e_rd;
    logic [7:0] e_oe, e_out;
    w    = wait_of(k);
    last = we ? w + 2 : w + 3;
    check("ready_pre", 8'(req_ready[k]), 8'h01);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk);
    #1;
    if (chain) begin
      req_we[k]    = nwe;
      req_addr[k]  = naddr;
      req_wdata[k] = nwdata;
    end else begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'($urandom);
      req_addr[k]  = 8'($urandom);
      req_wdata[k] = 8'($urandom);
    end
    if (we) mem[addr] = wdata;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      e_wr  = we && c >= 1 && c <= w + 1;
      e_rd  = !we && c >= 2 && c <= w + 2;
      e_oe  = (c == 0 || e_wr) ? 8'hFF : 8'h00;
      e_out = (c == 0) ? addr : (e_wr ? wdata : 8'h00);
      if (!we && c == last) exp_rdata[k] = mem[addr];
      check("ale",   8'(bus_ale[k]),   8'(c == 0));
      check("wr",    8'(bus_wr[k]),    8'(e_wr));
      check("rd",    8'(bus_rd[k]),    8'(e_rd));
      check("oe",    bus_oe[k],        e_oe);
      if (e_oe == 8'hFF || (!we && c == 1)) check("out", bus_out[k], e_out);
      check("rspv",  8'(rsp_valid[k]), 8'(c == last));
      check("busy",  8'(busy[k]),      8'h01);
      check("ready", 8'(req_ready[k]), 8'h00);
      check("rdata", rsp_rdata[k],     exp_rdata[k]);
      check("onehot", 8'(32'(bus_ale[k]) + 32'(bus_wr[k]) + 32'(bus_rd[k]) <= 1), 8'h01);
      // The target only presents the real data in the final RDATA cycle.
      bus_in[k] = (!we && c == w + 2) ? mem[addr] : 8'($urandom);
      if (c == abort_at) begin
        #2 rst_n[k] = 1'b0;
        exp_rdata[k] = 8'h00;
        #1 check_quiet(k, "abort");
        #1 rst_n[k] = 1'b1;
        @(negedge clk);
        check_quiet(k, "post_abort");
        check("post_abort_ready", 8'(req_ready[k]), 8'h01);
        return;
      end
    end
    @(negedge clk);
    check_quiet(k, "idle");
    check("idle_ready", 8'(req_ready[k]), 8'h01);
  endtask

  task automatic rand_txns(input int k, input int n);
    for (int i = 0; i < n; i++)
      run_txn(k, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00, -1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < N; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 8'h00;
      req_wdata[k] = 8'h00;
      bus_in[k]    = 8'h00;
      exp_rdata[k] = 8'h00;
    end
    #2;
    for (int k = 0; k < N; k++) check_quiet(k, "reset");
    @(negedge clk);
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < N; k++) check("reset_ready", 8'(req_ready[k]), 8'h01);
    @(negedge clk);

    // W=1: directed write, read, then a write that must not disturb rsp_rdata.
    run_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    mem[8'h10] = 8'h5A;
    run_txn(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_txn(0, 1'b1, 8'h77, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    check("rdata_hold", rsp_rdata[0], 8'h5A);
    run_txn(0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    rand_txns(0, 10);

    // W=0: read then write with req_valid held high across both.
    run_txn(1, 1'b0, 8'h44, 8'h00, 1'b1, 1'b1, 8'h45, 8'h99, -1);
    run_txn(1, 1'b1, 8'h45, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_txn(1, 1'b0, 8'h45, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    rand_txns(1, 10);

    // W=7: long read, then a read aborted by reset during RDATA, then recovery.
    run_txn(2, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_txn(2, 1'b0, 8'h82, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 4);
    run_txn(2, 1'b1, 8'h90, 8'h6E, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    check("rdata_after_abort", rsp_rdata[2], 8'h00);
    run_txn(2, 1'b0, 8'h90, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    rand_txns(2, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_mem_port.md
# tiny_cpu_mem_port

Bus initiator that lets the tiny CPU core reach external memory and I/O over the TinyTapeout bidirectional `uio` pins. It takes one load/store request at a time from the core, runs a multiplexed address/data cycle on the pins (address phase, then data phase with programmable wait states), and returns a response. It sits between the core's memory request port and the top-level `uio_out`/`uio_oe`/`uio_in` pins and a few `uo_out` strobe bits.

## Interface
- `WAIT_CYCLES`, default 1: extra data-phase cycles (legal range 0..7).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  target address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle pulse: transaction complete.
- `rsp_rdata`  out  8  read data; holds until the next read completes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `bus_out`  out  8  drives `uio_out`.
- `bus_oe`  out  8  drives `uio_oe`; always 8'hFF or 8'h00.
- `bus_in`  in  8  from `uio_in`.
- `bus_ale`  out  1  address latch enable.
- `bus_wr`  out  1  write strobe, active-high.
- `bus_rd`  out  1  read strobe, active-high.

## Operation
- States: IDLE, ADDR, WDATA, TURN, RDATA, DONE.
- IDLE: `req_ready`=1, `bus_oe`=00, `bus_out`=00, strobes 0. On an edge with `req_valid`&`req_ready`, latch `req_we`/`req_addr`/`req_wdata` internally and go to ADDR. After acceptance, core inputs are don't-care.
- ADDR (1 cycle): `bus_out`=addr, `bus_oe`=FF, `bus_ale`=1. Go to WDATA if write, else TURN.
- WDATA (WAIT_CYCLES+1 cycles): `bus_out`=wdata, `bus_oe`=FF, `bus_wr`=1. Then go to DONE.
- TURN (1 cycle): `bus_oe`=00, `bus_out`=00, no strobes (bus turnaround). Then go to RDATA.
- RDATA (WAIT_CYCLES+1 cycles): `bus_oe`=00, `bus_rd`=1. On the edge that leaves RDATA, capture `bus_in` into `rsp_rdata`. Then go to DONE.
- DONE (1 cycle): `rsp_valid`=1, `bus_oe`=00, no strobes. Then go to IDLE.
- The wait counter is 3 bits. It loads WAIT_CYCLES on entry to WDATA/RDATA and decrements each cycle; exit when it is 0.
- Writes leave `rsp_rdata` unchanged.
- `req_valid` outside IDLE is ignored; there is no queuing.
- Exactly one strobe (`ale`/`wr`/`rd`) is high in any cycle, or none.

## Timing
- All outputs are registers or decodes of the state register only; no combinational path from any input to any output.
- Reset (async, `rst_n`=0): state=IDLE immediately; `bus_oe`=00, `bus_out`=00, all strobes 0, `rsp_valid`=0, `busy`=0, `rsp_rdata`=00. `req_ready`=1 once `rst_n` is high.
- Reset mid-transaction: abort with no `rsp_valid`; `rsp_rdata` clears to 00.
- Cycle 0 is the first cycle after the accepting edge.
- Write: ADDR at cycle 0; `bus_wr` high for cycles 1..W+1 (W = WAIT_CYCLES); `rsp_valid` at cycle W+2; `req_ready` high at cycle W+3.
- Read: ADDR at cycle 0; TURN at cycle 1; `bus_rd` high for cycles 2..W+2, with `bus_in` sampled at the end of cycle W+2; `rsp_valid` and new `rsp_rdata` at cycle W+3; `req_ready` high at cycle W+4.
- Back-to-back: a request held high is accepted on the edge ending the first IDLE cycle after DONE, so there is a minimum one IDLE cycle between transactions.
- WAIT_CYCLES=0: data phase lasts exactly 1 cycle.

## Test plan
- Write, W=1: addr 8'h3C, wdata 8'hA5 → cycle 0 `bus_out`=3C, `bus_ale`=1, `bus_oe`=FF; cycles 1–2 `bus_out`=A5, `bus_wr`=1; cycle 3 `rsp_valid`=1, `bus_oe`=00.
- Read, W=1: addr 8'h10, `bus_in`=8'h5A during RDATA → `bus_oe`=00 from cycle 1; `bus_rd` high in cycles 2–3; cycle 4 `rsp_valid`=1, `rsp_rdata`=5A. A following write leaves `rsp_rdata`=5A.
- W=0, read then write held back-to-back → read `rsp_valid` at cycle 3, one IDLE cycle, then write ADDR; write `rsp_valid` 2 cycles after its ADDR.
- Latch check: change `req_addr`/`req_wdata`/`req_we` every cycle after acceptance → pins show the originally accepted values; `req_ready`=0 throughout.
- Reset mid-RDATA: assert `rst_n`=0 between edges → outputs go idle before the next edge; no `rsp_valid`; `rsp_rdata`=00. After release, a fresh write completes normally.
- W=7 read → exactly 8 `bus_rd` cycles; `rsp_valid` at cycle 10; one strobe at most per cycle throughout.
